// File: rtl/sys_bus_ctrl.sv
// Multi-master system bus controller: round-robin arbitration over NUM_MASTERS,
// then one slave transaction (ALE address phase, strobed data phase with wait/timeout).
module sys_bus_ctrl #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 8,
    parameter int NUM_MASTERS = 2,
    parameter int TIMEOUT     = 15
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_MASTERS-1:0]            m_req,
    input  logic [NUM_MASTERS-1:0]            m_we,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wdata,
    output logic [NUM_MASTERS-1:0]            m_gnt,
    output logic [NUM_MASTERS-1:0]            m_done,
    output logic                              m_err,
    output logic [DATA_WIDTH-1:0]             m_rdata,
    output logic                              s_ale,
    output logic [ADDR_WIDTH-1:0]             s_addr,
    output logic                              s_read_en,
    output logic                              s_write_en,
    output logic [DATA_WIDTH-1:0]             s_wdata,
    input  logic [DATA_WIDTH-1:0]             s_rdata,
    input  logic                              s_ready
);

    localparam int PTR_W = $clog2(NUM_MASTERS);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

    state_t                 state, state_nxt;
    logic [PTR_W-1:0]       ptr, ptr_nxt;
    logic [PTR_W-1:0]       gnt_idx, gnt_idx_nxt;
    logic                   we_r, we_nxt;
    logic [DATA_WIDTH-1:0]  wdata_r, wdata_nxt;
    logic [7:0]             cnt, cnt_nxt;

    logic [NUM_MASTERS-1:0] m_gnt_nxt, m_done_nxt;
    logic                   m_err_nxt;
    logic [DATA_WIDTH-1:0]  m_rdata_nxt;
    logic                   s_ale_nxt;
    logic [ADDR_WIDTH-1:0]  s_addr_nxt;
    logic                   s_read_en_nxt, s_write_en_nxt;
    logic [DATA_WIDTH-1:0]  s_wdata_nxt;

    logic                   req_found;
    logic [PTR_W-1:0]       req_idx;

    function automatic logic [NUM_MASTERS-1:0] onehot(input logic [PTR_W-1:0] idx);
        logic [NUM_MASTERS-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Round-robin search: first requester at or after ptr, wrapping past NUM_MASTERS-1.
    always_comb begin
        logic [PTR_W:0]   cand_w;
        logic [PTR_W-1:0] cand;
        req_found = 1'b0;
        req_idx   = '0;
        cand_w    = '0;
        cand      = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            cand_w = {1'b0, ptr} + (PTR_W+1)'(i);
            if (cand_w >= (PTR_W+1)'(NUM_MASTERS))
                cand_w = cand_w - (PTR_W+1)'(NUM_MASTERS);
            cand = cand_w[PTR_W-1:0];
            if (!req_found && m_req[cand]) begin
                req_found = 1'b1;
                req_idx   = cand;
            end
        end
    end

    always_comb begin
        state_nxt      = state;
        ptr_nxt        = ptr;
        gnt_idx_nxt    = gnt_idx;
        we_nxt         = we_r;
        wdata_nxt      = wdata_r;
        cnt_nxt        = cnt;
        m_gnt_nxt      = m_gnt;
        m_done_nxt     = '0;
        m_err_nxt      = m_err;
        m_rdata_nxt    = m_rdata;
        s_ale_nxt      = 1'b0;
        s_addr_nxt     = s_addr;
        s_read_en_nxt  = 1'b0;
        s_write_en_nxt = 1'b0;
        s_wdata_nxt    = '0;

        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (req_found) begin
                    state_nxt   = ADDR;
                    gnt_idx_nxt = req_idx;
                    we_nxt      = m_we[req_idx];
                    wdata_nxt   = m_wdata[int'(req_idx)*DATA_WIDTH +: DATA_WIDTH];
                    s_addr_nxt  = m_addr[int'(req_idx)*ADDR_WIDTH +: ADDR_WIDTH];
                    m_gnt_nxt   = onehot(req_idx);
                    s_ale_nxt   = 1'b1;
                end
            end
            ADDR: begin
                state_nxt      = DATA;
                cnt_nxt        = 8'd1;
                s_read_en_nxt  = !we_r;
                s_write_en_nxt = we_r;
                s_wdata_nxt    = we_r ? wdata_r : '0;
            end
            DATA: begin
                // Ready takes precedence over a timeout landing on the same cycle.
                if (s_ready) begin
                    state_nxt   = RESP;
                    cnt_nxt     = '0;
                    m_rdata_nxt = we_r ? '0 : s_rdata;
                    m_err_nxt   = 1'b0;
                    m_done_nxt  = onehot(gnt_idx);
                end else if (cnt >= 8'(TIMEOUT)) begin
                    state_nxt   = RESP;
                    cnt_nxt     = '0;
                    m_rdata_nxt = '0;
                    m_err_nxt   = 1'b1;
                    m_done_nxt  = onehot(gnt_idx);
                end else begin
                    cnt_nxt        = cnt + 8'd1;
                    s_read_en_nxt  = !we_r;
                    s_write_en_nxt = we_r;
                    s_wdata_nxt    = we_r ? wdata_r : '0;
                end
            end
            RESP: begin
                state_nxt = IDLE;
                m_gnt_nxt = '0;
                ptr_nxt   = (gnt_idx == PTR_W'(NUM_MASTERS-1)) ? '0 : gnt_idx + 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= '0;
            gnt_idx    <= '0;
            we_r       <= 1'b0;
            wdata_r    <= '0;
            cnt        <= '0;
            m_gnt      <= '0;
            m_done     <= '0;
            m_err      <= 1'b0;
            m_rdata    <= '0;
            s_ale      <= 1'b0;
            s_addr     <= '0;
            s_read_en  <= 1'b0;
            s_write_en <= 1'b0;
            s_wdata    <= '0;
        end else begin
            state      <= state_nxt;
            ptr        <= ptr_nxt;
            gnt_idx    <= gnt_idx_nxt;
            we_r       <= we_nxt;
            wdata_r    <= wdata_nxt;
            cnt        <= cnt_nxt;
            m_gnt      <= m_gnt_nxt;
            m_done     <= m_done_nxt;
            m_err      <= m_err_nxt;
            m_rdata    <= m_rdata_nxt;
            s_ale      <= s_ale_nxt;
            s_addr     <= s_addr_nxt;
            s_read_en  <= s_read_en_nxt;
            s_write_en <= s_write_en_nxt;
            s_wdata    <= s_wdata_nxt;
        end
    end

endmodule

// File: tb/tb_sys_bus_ctrl.sv
// Bench for sys_bus_ctrl with four masters: table of single transactions,
// then reset abort, arbitration rotation/wrap and request-drop sequences.
module tb_sys_bus_ctrl;

    localparam int DW = 32;
    localparam int AW = 8;
    localparam int NM = 4;
    localparam int TO = 15;

    logic             clk;
    logic             rst;
    logic [NM-1:0]    m_req;
    logic [NM-1:0]    m_we;
    logic [NM*AW-1:0] m_addr;
    logic [NM*DW-1:0] m_wdata;
    logic [NM-1:0]    m_gnt;
    logic [NM-1:0]    m_done;
    logic             m_err;
    logic [DW-1:0]    m_rdata;
    logic             s_ale;
    logic [AW-1:0]    s_addr;
    logic             s_read_en;
    logic             s_write_en;
    logic [DW-1:0]    s_wdata;
    logic [DW-1:0]    s_rdata;
    logic             s_ready;

    sys_bus_ctrl #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .NUM_MASTERS(NM),
        .TIMEOUT    (TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .m_req     (m_req),
        .m_we      (m_we),
        .m_addr    (m_addr),
        .m_wdata   (m_wdata),
        .m_gnt     (m_gnt),
        .m_done    (m_done),
        .m_err     (m_err),
        .m_rdata   (m_rdata),
        .s_ale     (s_ale),
        .s_addr    (s_addr),
        .s_read_en (s_read_en),
        .s_write_en(s_write_en),
        .s_wdata   (s_wdata),
        .s_rdata   (s_rdata),
        .s_ready   (s_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          master;
        logic        we;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] srdata;
        int          ready_cyc;   // DATA cycle on which s_ready is raised, 0 = never
        int          exp_strobes;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } txn_t;

    txn_t tbl[6];
    int   n_pass;
    int   n_total;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic run_txn(input int k, input txn_t t);
        int         strobes, ale_seen, kind_bad, addr_bad, wdata_bad;
        logic       got_done;
        logic [3:0] exp_g, done_v;
        logic [31:0] rd;
        logic       er;
        strobes = 0; ale_seen = 0; kind_bad = 0; addr_bad = 0; wdata_bad = 0;
        got_done = 1'b0; done_v = '0; rd = '0; er = 1'b0;
        exp_g = 4'b0001 << t.master;

        m_req[t.master]            = 1'b1;
        m_we[t.master]             = t.we;
        m_addr[t.master*AW +: AW]  = t.addr;
        m_wdata[t.master*DW +: DW] = t.wdata;
        s_rdata                    = t.srdata;
        s_ready                    = 1'b0;

        @(negedge clk);
        check($sformatf("t%0d_ale", k), s_ale, 1);
        check($sformatf("t%0d_gnt", k), m_gnt, exp_g);
        check($sformatf("t%0d_ale_addr", k), s_addr, t.addr);

        for (int c = 0; c < 40 && !got_done; c++) begin
            @(negedge clk);
            if (m_done != '0) begin
                got_done = 1'b1;
                done_v   = m_done;
                rd       = m_rdata;
                er       = m_err;
                s_ready  = 1'b0;
                m_req[t.master] = 1'b0;
            end else begin
                if (s_ale) ale_seen++;
                if (s_read_en || s_write_en) begin
                    strobes++;
                    if (s_write_en != t.we || s_read_en == t.we) kind_bad++;
                    if (s_addr != t.addr) addr_bad++;
                    if (s_wdata != (t.we ? t.wdata : 32'h0)) wdata_bad++;
                    s_ready = (t.ready_cyc != 0) && (strobes == t.ready_cyc);
                end else begin
                    s_ready = 1'b0;
                end
            end
        end
        m_req[t.master] = 1'b0;

        check($sformatf("t%0d_done_seen", k), got_done, 1);
        check($sformatf("t%0d_done", k), done_v, exp_g);
        check($sformatf("t%0d_rdata", k), rd, t.exp_rdata);
        check($sformatf("t%0d_err", k), er, t.exp_err);
        check($sformatf("t%0d_strobes", k), strobes, t.exp_strobes);
        check($sformatf("t%0d_strobe_kind", k), kind_bad, 0);
        check($sformatf("t%0d_addr_held", k), addr_bad, 0);
        check($sformatf("t%0d_wdata", k), wdata_bad, 0);
        check($sformatf("t%0d_ale_once", k), ale_seen, 0);

        @(negedge clk);
        check($sformatf("t%0d_done_pulse", k), m_done, 0);
        check($sformatf("t%0d_idle_gnt", k), m_gnt, 0);
        check($sformatf("t%0d_rdata_hold", k), m_rdata, t.exp_rdata);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_gnt"}, m_gnt, 0);
        check({tag, "_done"}, m_done, 0);
        check({tag, "_err"}, m_err, 0);
        check({tag, "_rdata"}, m_rdata, 0);
        check({tag, "_ale"}, s_ale, 0);
        check({tag, "_saddr"}, s_addr, 0);
        check({tag, "_rd_en"}, s_read_en, 0);
        check({tag, "_wr_en"}, s_write_en, 0);
        check({tag, "_swdata"}, s_wdata, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] exp_arb[8];
        logic       any_done;
        int         got;

        n_pass = 0; n_total = 0;
        rst = 1'b1; m_req = '0; m_we = '0; m_addr = '0; m_wdata = '0;
        s_rdata = '0; s_ready = 1'b0;

        //             master we    addr   wdata         srdata        rdy strb exp_rdata     err
        tbl[0] = '{0, 1'b0, 8'h3C, 32'h0,        32'hDEADBEEF, 1,  1,  32'hDEADBEEF, 1'b0};
        tbl[1] = '{1, 1'b1, 8'h05, 32'h12345678, 32'hAAAA5555, 4,  4,  32'h0,        1'b0};
        tbl[2] = '{2, 1'b0, 8'h80, 32'h0,        32'h11111111, 0,  15, 32'h0,        1'b1};
        tbl[3] = '{3, 1'b0, 8'hFF, 32'h0,        32'hCAFEF00D, 15, 15, 32'hCAFEF00D, 1'b0};
        tbl[4] = '{0, 1'b1, 8'h00, 32'hFFFFFFFF, 32'h22222222, 2,  2,  32'h0,        1'b0};
        tbl[5] = '{1, 1'b0, 8'h7E, 32'h0,        32'h00000001, 3,  3,  32'h00000001, 1'b0};

        exp_arb = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b0100};

        @(posedge clk); @(posedge clk);
        @(negedge clk);
        check_all_zero("rst0");
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) run_txn(i, tbl[i]);

        // Abort a read in DATA with an asynchronous reset.
        m_req[3] = 1'b1; m_we[3] = 1'b0; m_addr[3*AW +: AW] = 8'h5A; s_ready = 1'b0;
        @(negedge clk);
        check("abort_gnt", m_gnt, 4'b1000);
        @(negedge clk); @(negedge clk); @(negedge clk);
        check("abort_in_data", s_read_en, 1);
        rst = 1'b1;
        m_req = '0;
        #1;
        check_all_zero("abort");
        @(negedge clk);
        rst = 1'b0;
        any_done = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            any_done = any_done | (|m_done);
        end
        check("abort_no_done", any_done, 0);
        check("abort_idle_gnt", m_gnt, 0);

        // All masters requesting: rotation from ptr=0, then a lone master 2 after ptr=3.
        m_we = '0;
        m_addr = {8'h33, 8'h22, 8'h11, 8'h00};
        s_rdata = 32'h0;
        s_ready = 1'b1;
        m_req = 4'b1111;
        got = 0;
        for (int c = 0; c < 80 && got < 8; c++) begin
            @(negedge clk);
            if (s_ale) begin
                check($sformatf("arb_gnt%0d", got), m_gnt, exp_arb[got]);
                got++;
                if (got == 7) m_req = 4'b0100;
            end
        end
        check("arb_count", got, 8);
        m_req = '0;
        any_done = 1'b0;
        for (int c = 0; c < 10 && !any_done; c++) begin
            @(negedge clk);
            any_done = |m_done;
        end
        check("arb_last_done", any_done, 1);
        s_ready = 1'b0;
        @(negedge clk);

        // Master 1 drops its request and changes inputs mid-transaction.
        m_req[1] = 1'b1; m_we[1] = 1'b0; m_addr[AW +: AW] = 8'h44;
        s_rdata = 32'h0BADF00D; s_ready = 1'b0;
        @(negedge clk);
        check("drop_ale_addr", s_addr, 8'h44);
        @(negedge clk);
        m_req[1] = 1'b0; m_addr[AW +: AW] = 8'h99; m_we[1] = 1'b1;
        m_wdata[DW +: DW] = 32'h55555555;
        @(negedge clk);
        check("drop_addr_held", s_addr, 8'h44);
        check("drop_still_read", s_read_en, 1);
        check("drop_no_write", s_write_en, 0);
        s_ready = 1'b1;
        @(negedge clk);
        s_ready = 1'b0;
        check("drop_done", m_done, 4'b0010);
        check("drop_rdata", m_rdata, 32'h0BADF00D);
        check("drop_err", m_err, 0);
        @(negedge clk);
        check("drop_idle_gnt", m_gnt, 0);
        check("drop_done_pulse", m_done, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
